mux_sched: RTL and testbench

MUX_SCHED -- requirements
Module: mux_sched

---
 rtl/mux_sched.sv | 120 ++++++++++++
 tb/tb_mux_sched.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mux_sched.sv
`default_nettype none
// ============================================================================
// Module   : mux_sched
// Brief    : N-channel data multiplexer with direct-select or round-robin
//            scheduling into a one-entry registered output stage with
//            valid/ready handshaking on both sides.
// Options  : define MUX_SCHED_CNT_EN to add the 16-bit xfer_cnt output that
//            counts accepted output transfers.
// Revision : 1.0 - initial release
// ============================================================================
module mux_sched #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] d,
    input  logic [NUM_CH-1:0]       d_valid,
    output logic [NUM_CH-1:0]       d_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        y,
    output logic                    y_valid,
    input  logic                    y_ready,
    output logic [SEL_W-1:0]        y_ch
`ifdef MUX_SCHED_CNT_EN
    ,
    output logic [15:0]             xfer_cnt
`endif
);

    // Output register may be (re)loaded when empty or being drained this cycle
    logic             load_en;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic [SEL_W-1:0] last_ptr;

    assign load_en = ~y_valid | y_ready;

    // Grant decision: direct select, or first valid channel after last_ptr
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (!mode) begin
            // An out-of-range sel matches no channel and so grants nothing
            for (int i = 0; i < NUM_CH; i++) begin
                if (sel == SEL_W'(i) && d_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            // Walk offsets from farthest to nearest so the nearest valid wins
            for (int k = NUM_CH; k >= 1; k--) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (i == ((int'(last_ptr) + k) % NUM_CH) && d_valid[i]) begin
                        grant_vld = 1'b1;
                        grant_idx = SEL_W'(i);
                    end
                end
            end
        end
    end

    // Data of the granted channel
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data = d[i*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot accept strobe, suppressed under backpressure and during reset
    always_comb begin
        d_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_vld && load_en && !rst && grant_idx == SEL_W'(i)) begin
                d_ready[i] = 1'b1;
            end
        end
    end

    // Output register and round-robin pointer; pointer moves only on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y        <= '0;
            y_valid  <= 1'b0;
            y_ch     <= '0;
            last_ptr <= SEL_W'(NUM_CH - 1);
        end else if (load_en) begin
            if (grant_vld) begin
                y        <= grant_data;
                y_ch     <= grant_idx;
                y_valid  <= 1'b1;
                last_ptr <= grant_idx;
            end else begin
                y_valid  <= 1'b0;
            end
        end
    end

`ifdef MUX_SCHED_CNT_EN
    // Count completed output handshakes, wrapping at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_cnt <= '0;
        end else if (y_valid && y_ready) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end
`else
    // Transfer counter not built in this configuration
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_sched
// Brief    : Self-checking bench for mux_sched (WIDTH=8, NUM_CH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_sched;

    localparam int WIDTH  = 8;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam logic [31:0] DATA = 32'h44A5_2211;

    logic                    clk;
    logic                    rst;
    logic [NUM_CH*WIDTH-1:0] d;
    logic [NUM_CH-1:0]       d_valid;
    logic [NUM_CH-1:0]       d_ready;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        y;
    logic                    y_valid;
    logic                    y_ready;
    logic [SEL_W-1:0]        y_ch;
`ifdef MUX_SCHED_CNT_EN
    logic [15:0]             xfer_cnt;
`endif

    int n_total;
    int n_pass;

    mux_sched #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .d        (d),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .mode     (mode),
        .sel      (sel),
        .y        (y),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .y_ch     (y_ch)
`ifdef MUX_SCHED_CNT_EN
        ,
        .xfer_cnt (xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  dv;
        logic        yr;
        logic [31:0] data;
        logic [3:0]  exp_dr;
        logic [7:0]  exp_y;
        logic        exp_yv;
        logic [1:0]  exp_ch;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one vector mid-cycle, check the strobe, then the registered result
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        mode    = v.mode;
        sel     = v.sel;
        d_valid = v.dv;
        y_ready = v.yr;
        d       = v.data;
        #1;
        chk($sformatf("v%0d d_ready", idx), 32'(d_ready), 32'(v.exp_dr));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d y", idx),       32'(y),       32'(v.exp_y));
        chk($sformatf("v%0d y_valid", idx), 32'(y_valid), 32'(v.exp_yv));
        chk($sformatf("v%0d y_ch", idx),    32'(y_ch),    32'(v.exp_ch));
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        //          mode sel   dv       yr  data            dr       y      yv  ch
        vecs[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, DATA,         4'b0100, 8'hA5, 1'b1, 2'd2};
        vecs[1]  = '{1'b0, 2'd1, 4'b0100, 1'b1, DATA,         4'b0000, 8'hA5, 1'b0, 2'd2};
        vecs[2]  = '{1'b0, 2'd3, 4'b1000, 1'b0, DATA,         4'b1000, 8'h44, 1'b1, 2'd3};
        vecs[3]  = '{1'b1, 2'd0, 4'b1111, 1'b0, DATA,         4'b0000, 8'h44, 1'b1, 2'd3};
        vecs[4]  = '{1'b0, 2'd0, 4'b1111, 1'b0, DATA,         4'b0000, 8'h44, 1'b1, 2'd3};
        vecs[5]  = '{1'b1, 2'd1, 4'b1111, 1'b0, 32'h0,        4'b0000, 8'h44, 1'b1, 2'd3};
        vecs[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, DATA,         4'b0001, 8'h11, 1'b1, 2'd0};
        vecs[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, DATA,         4'b0010, 8'h22, 1'b1, 2'd1};
        vecs[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, DATA,         4'b0100, 8'hA5, 1'b1, 2'd2};
        vecs[9]  = '{1'b1, 2'd0, 4'b1111, 1'b1, DATA,         4'b1000, 8'h44, 1'b1, 2'd3};
        vecs[10] = '{1'b1, 2'd0, 4'b1111, 1'b1, DATA,         4'b0001, 8'h11, 1'b1, 2'd0};
        vecs[11] = '{1'b1, 2'd0, 4'b1001, 1'b1, DATA,         4'b1000, 8'h44, 1'b1, 2'd3};
        vecs[12] = '{1'b1, 2'd0, 4'b1001, 1'b1, DATA,         4'b0001, 8'h11, 1'b1, 2'd0};
        vecs[13] = '{1'b1, 2'd0, 4'b0000, 1'b1, DATA,         4'b0000, 8'h11, 1'b0, 2'd0};
        vecs[14] = '{1'b1, 2'd0, 4'b0010, 1'b0, DATA,         4'b0010, 8'h22, 1'b1, 2'd1};
        vecs[15] = '{1'b1, 2'd0, 4'b0010, 1'b1, 32'h44A5_3311, 4'b0010, 8'h33, 1'b1, 2'd1};
        vecs[16] = '{1'b0, 2'd2, 4'b0000, 1'b1, DATA,         4'b0000, 8'h33, 1'b0, 2'd1};

        // Asynchronous reset asserted between clock edges with all channels valid
        rst = 1'b0; mode = 1'b1; sel = '0; d_valid = 4'b1111; y_ready = 1'b1; d = DATA;
        #2;
        rst = 1'b1;
        #1;
        chk("reset y",       32'(y),       32'h0);
        chk("reset y_valid", 32'(y_valid), 32'h0);
        chk("reset y_ch",    32'(y_ch),    32'h0);
        chk("reset d_ready", 32'(d_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("reset hold d_ready", 32'(d_ready), 32'h0);
        chk("reset hold y_valid", 32'(y_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            apply(vecs[i], i);
        end

        // Reset mid-operation discards a held word and restores channel-0 priority
        @(negedge clk);
        mode = 1'b0; sel = 2'd2; d_valid = 4'b0100; y_ready = 1'b0; d = DATA;
        @(posedge clk);
        #1;
        chk("midrst load y", 32'(y), 32'hA5);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst y",       32'(y),       32'h0);
        chk("midrst y_valid", 32'(y_valid), 32'h0);
        chk("midrst y_ch",    32'(y_ch),    32'h0);
        chk("midrst d_ready", 32'(d_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mode = 1'b1; d_valid = 4'b1111; y_ready = 1'b1;
        #1;
        chk("post-rst d_ready", 32'(d_ready), 32'b0001);
        @(posedge clk);
        #1;
        chk("post-rst y_ch", 32'(y_ch), 32'd0);
        chk("post-rst y",    32'(y),    32'h11);

`ifdef MUX_SCHED_CNT_EN
        // 65537 output handshakes after reset wrap the counter to 1
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("cnt reset", 32'(xfer_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mode = 1'b1; d_valid = 4'b1111; y_ready = 1'b1;
        for (int c = 0; c < 65538; c++) begin
            @(posedge clk);
        end
        #1;
        chk("cnt wrap", 32'(xfer_cnt), 32'h1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
